// File: rtl/nmr_bstrm_multi_dpath.sv
`default_nettype none
// ============================================================================
// Module      : nmr_bstrm_multi_dpath
// Description : Multi-channel NMR bitstream datapath fed by a first-word-
//               fall-through instruction FIFO. Plays pattern words (MSB
//               first, with repeat count) and constant runs on NCH masked
//               channels, back-to-back with no gap cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module nmr_bstrm_multi_dpath #(
    parameter int DATA_WIDTH = 20,
    parameter int NCH        = 4,
    parameter int REP_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic                          wr_en,
    input  logic [1:0]                    wr_mode,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [REP_WIDTH-1:0]          wr_rep,
    input  logic [NCH-1:0]                wr_chmask,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [NCH-1:0]                OUT,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_WW = 2 + DATA_WIDTH + REP_WIDTH + NCH;

    localparam logic [1:0] c_MODE_PAT  = 2'b00;
    localparam logic [1:0] c_MODE_ZERO = 2'b01;
    localparam logic [1:0] c_MODE_ONE  = 2'b10;
    localparam logic [1:0] c_MODE_END  = 2'b11;

    localparam logic [c_AW:0]         c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_PAT_LAST = DATA_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Instruction FIFO storage and pointers (one extra wrap bit each)
    // ------------------------------------------------------------------
    logic [c_WW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wptr;
    logic [c_AW:0]   r_rptr;

    logic [c_AW:0]           w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_ok;
    logic                    w_ovf_set;
    logic                    w_pop;
    logic [c_WW-1:0]         w_head;
    logic [1:0]              w_head_mode;
    logic [DATA_WIDTH-1:0]   w_head_data;
    logic [REP_WIDTH-1:0]    w_head_rep;
    logic [NCH-1:0]          w_head_mask;
    logic [DATA_WIDTH-1:0]   w_load_len;

    // Currently playing instruction
    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   r_len;
    logic [REP_WIDTH-1:0]    r_rep;
    logic [NCH-1:0]          r_mask;

    logic                    w_last;
    logic                    w_bit;
    logic [NCH-1:0]          w_out_val;

    assign w_count    = r_wptr - r_rptr;
    assign w_full     = (w_count == c_DEPTH);
    assign w_empty    = (w_count == '0);
    assign full       = w_full;
    assign fifo_count = w_count;

    // A write is judged against the registered full flag; ABORT drops it.
    assign w_wr_ok   = wr_en && !w_full && !ABORT;
    assign w_ovf_set = wr_en &&  w_full && !ABORT;

    assign w_head      = r_mem[r_rptr[c_AW-1:0]];
    assign w_head_mode = w_head[c_WW-1 -: 2];
    assign w_head_data = w_head[c_WW-3 -: DATA_WIDTH];
    assign w_head_rep  = w_head[NCH +: REP_WIDTH];
    assign w_head_mask = w_head[NCH-1:0];

    // Counter holds cycles-remaining minus one; zero-length runs play once.
    assign w_load_len = (w_head_mode == c_MODE_PAT) ? c_PAT_LAST :
                        (w_head_data == '0)         ? '0 :
                                                      (w_head_data - 1'b1);

    assign w_last = (r_len == '0) && ((r_mode != c_MODE_PAT) || (r_rep == '0));

    assign w_pop = !ABORT && !w_empty &&
                   (((r_state == S_IDLE) && START) ||
                    (r_state == S_STALL) ||
                    ((r_state == S_RUN) && (r_mode != c_MODE_END) && w_last));

    assign w_bit = (r_mode == c_MODE_PAT) ? r_shift[DATA_WIDTH-1] :
                   (r_mode == c_MODE_ONE);
    assign w_out_val = {NCH{w_bit}} & r_mask;

    // FIFO storage write; contents need no reset since pointers qualify them
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_mem[r_wptr[c_AW-1:0]] <= {wr_mode, wr_data, wr_rep, wr_chmask};
        end
    end

    // FIFO pointer update; ABORT flushes by clearing both pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (ABORT) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)   r_rptr <= r_rptr + 1'b1;
        end
    end

    // Playback sequencer: state, instruction counters and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_mode   <= c_MODE_ZERO;
            r_data   <= '0;
            r_shift  <= '0;
            r_len    <= '0;
            r_rep    <= '0;
            r_mask   <= '0;
            OUT      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (w_ovf_set) overflow <= 1'b1;

            // Loading at the pop edge makes the first bit appear one edge later.
            if (w_pop) begin
                r_mode  <= w_head_mode;
                r_data  <= w_head_data;
                r_shift <= w_head_data;
                r_rep   <= w_head_rep;
                r_mask  <= w_head_mask;
                r_len   <= w_load_len;
            end

            if (ABORT) begin
                r_state <= S_IDLE;
                OUT     <= '0;
                BUSY    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        OUT  <= '0;
                        BUSY <= 1'b0;
                        if (START && !w_empty) begin
                            r_state  <= S_RUN;
                            underrun <= 1'b0;
                            overflow <= w_ovf_set;
                        end
                    end
                    S_RUN: begin
                        if (r_mode == c_MODE_END) begin
                            OUT     <= '0;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            OUT  <= w_out_val;
                            BUSY <= 1'b1;
                            if (r_len != '0) begin
                                r_len   <= r_len - 1'b1;
                                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                            end else if ((r_mode == c_MODE_PAT) && (r_rep != '0)) begin
                                r_rep   <= r_rep - 1'b1;
                                r_len   <= c_PAT_LAST;
                                r_shift <= r_data;
                            end else if (w_empty) begin
                                r_state  <= S_STALL;
                                underrun <= 1'b1;
                            end
                        end
                    end
                    S_STALL: begin
                        OUT  <= '0;
                        BUSY <= 1'b1;
                        if (!w_empty) r_state <= S_RUN;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        OUT     <= '0;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nmr_bstrm_multi_dpath.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmr_bstrm_multi_dpath
// Description : Directed self-checking bench for nmr_bstrm_multi_dpath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmr_bstrm_multi_dpath;

    localparam logic [1:0] M_PAT  = 2'b00;
    localparam logic [1:0] M_ZERO = 2'b01;
    localparam logic [1:0] M_ONE  = 2'b10;
    localparam logic [1:0] M_END  = 2'b11;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        ABORT;
    logic        wr_en;
    logic [1:0]  wr_mode;
    logic [19:0] wr_data;
    logic [7:0]  wr_rep;
    logic [3:0]  wr_chmask;
    logic        full;
    logic [3:0]  fifo_count;
    logic [3:0]  OUT;
    logic        BUSY;
    logic        DONE;
    logic        underrun;
    logic        overflow;

    int total;
    int bad;

    nmr_bstrm_multi_dpath #(
        .DATA_WIDTH(20), .NCH(4), .REP_WIDTH(8), .FIFO_DEPTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_data(wr_data), .wr_rep(wr_rep),
        .wr_chmask(wr_chmask), .full(full), .fifo_count(fifo_count),
        .OUT(OUT), .BUSY(BUSY), .DONE(DONE), .underrun(underrun), .overflow(overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [19:0] d,
                        input logic [7:0] r, input logic [3:0] k);
        wr_en = 1'b1; wr_mode = m; wr_data = d; wr_rep = r; wr_chmask = k;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (OUT !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || underrun !== 1'b0 ||
            overflow !== 1'b0 || fifo_count !== 4'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset: OUT=%h BUSY=%b DONE=%b und=%b ovf=%b cnt=%0d full=%b, want all 0",
                     OUT, BUSY, DONE, underrun, overflow, fifo_count, full);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [19:0] p;
        logic        b;
        logic [3:0]  e;
        p = 20'b10100011100011101110;
        push(M_ONE, 20'd10, 8'd0, 4'b0001);
        push(M_PAT, p, 8'd1, 4'b0011);
        push(M_END, 20'd0, 8'd0, 4'b0000);
        pulse_start();
        total++;
        if (BUSY !== 1'b0 || OUT !== 4'h0) begin
            bad++;
            $display("FAIL b2b_start_edge: BUSY=%b OUT=%h, want BUSY=0 OUT=0", BUSY, OUT);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i < 10) begin
                e = 4'b0001;
            end else begin
                b = p[19 - ((i - 10) % 20)];
                e = {2'b00, b, b};
            end
            total++;
            if (OUT !== e || BUSY !== 1'b1 || DONE !== 1'b0) begin
                bad++;
                $display("FAIL b2b_play cyc %0d: OUT=%h BUSY=%b DONE=%b, want OUT=%h BUSY=1 DONE=0",
                         i, OUT, BUSY, DONE, e);
            end
        end
        tick();
        total++;
        if (OUT !== 4'h0 || DONE !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done: OUT=%h DONE=%b BUSY=%b, want 0/1/0", OUT, DONE, BUSY);
        end
        tick();
        total++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_pulse: DONE=%b BUSY=%b, want 0/0", DONE, BUSY);
        end
    endtask

    task automatic test_const_runs();
        push(M_ZERO, 20'd7, 8'd0, 4'hF);
        push(M_ONE, 20'd0, 8'd0, 4'hF);
        push(M_END, 20'd0, 8'd0, 4'h0);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (OUT !== ((i == 7) ? 4'hF : 4'h0) || BUSY !== 1'b1 || DONE !== 1'b0) begin
                bad++;
                $display("FAIL const_run cyc %0d: OUT=%h BUSY=%b DONE=%b, want OUT=%h BUSY=1 DONE=0",
                         i, OUT, BUSY, DONE, (i == 7) ? 4'hF : 4'h0);
            end
        end
        tick();
        total++;
        if (DONE !== 1'b1 || OUT !== 4'h0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL const_done: DONE=%b OUT=%h BUSY=%b, want 1/0/0", DONE, OUT, BUSY);
        end
    endtask

    task automatic test_underrun();
        push(M_ONE, 20'd5, 8'd0, 4'hF);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (OUT !== 4'hF || BUSY !== 1'b1 || underrun !== (i == 4)) begin
                bad++;
                $display("FAIL und_run cyc %0d: OUT=%h BUSY=%b und=%b, want F/1/%0d",
                         i, OUT, BUSY, underrun, (i == 4));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'h0 || BUSY !== 1'b1 || underrun !== 1'b1 || DONE !== 1'b0) begin
                bad++;
                $display("FAIL und_stall cyc %0d: OUT=%h BUSY=%b und=%b DONE=%b, want 0/1/1/0",
                         i, OUT, BUSY, underrun, DONE);
            end
        end
        push(M_END, 20'd0, 8'd0, 4'h0);
        total++;
        if (OUT !== 4'h0 || BUSY !== 1'b1 || DONE !== 1'b0 || fifo_count !== 4'd1) begin
            bad++;
            $display("FAIL und_write: OUT=%h BUSY=%b DONE=%b cnt=%0d, want 0/1/0/1",
                     OUT, BUSY, DONE, fifo_count);
        end
        tick();
        total++;
        if (DONE !== 1'b0 || BUSY !== 1'b1 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL und_pop: DONE=%b BUSY=%b cnt=%0d, want 0/1/0", DONE, BUSY, fifo_count);
        end
        tick();
        total++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || OUT !== 4'h0) begin
            bad++;
            $display("FAIL und_done: DONE=%b BUSY=%b OUT=%h, want 1/0/0", DONE, BUSY, OUT);
        end
        tick();
        total++;
        if (underrun !== 1'b1 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL und_sticky: und=%b DONE=%b, want 1/0", underrun, DONE);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) push(M_ONE, 20'd2, 8'd0, 4'h2);
        push(M_END, 20'd0, 8'd0, 4'h0);
        total++;
        if (full !== 1'b1 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_fill: full=%b cnt=%0d ovf=%b, want 1/8/0", full, fifo_count, overflow);
        end
        push(M_ONE, 20'd3, 8'd0, 4'hF);
        total++;
        if (full !== 1'b1 || fifo_count !== 4'd8 || overflow !== 1'b1 || underrun !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drop: full=%b cnt=%0d ovf=%b und=%b, want 1/8/1/1",
                     full, fifo_count, overflow, underrun);
        end
        pulse_start();
        total++;
        if (overflow !== 1'b0 || underrun !== 1'b0 || fifo_count !== 4'd7 || full !== 1'b0) begin
            bad++;
            $display("FAIL ovf_start_clear: ovf=%b und=%b cnt=%0d full=%b, want 0/0/7/0",
                     overflow, underrun, fifo_count, full);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            total++;
            if (OUT !== 4'h2 || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL ovf_play cyc %0d: OUT=%h BUSY=%b, want 2/1", i, OUT, BUSY);
            end
        end
        tick();
        total++;
        if (DONE !== 1'b1 || OUT !== 4'h0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL ovf_done: DONE=%b OUT=%h cnt=%0d, want 1/0/0", DONE, OUT, fifo_count);
        end
    endtask

    task automatic test_rep_max();
        logic [19:0] p;
        p = 20'b10100011100011101110;
        push(M_PAT, p, 8'hFF, 4'h1);
        push(M_END, 20'd0, 8'd0, 4'h0);
        pulse_start();
        for (int i = 0; i < 5120; i++) begin
            tick();
            total++;
            if (OUT !== {3'b000, p[19 - (i % 20)]} || BUSY !== 1'b1 || DONE !== 1'b0) begin
                bad++;
                $display("FAIL rep_max cyc %0d: OUT=%h BUSY=%b DONE=%b, want OUT=%h BUSY=1 DONE=0",
                         i, OUT, BUSY, DONE, {3'b000, p[19 - (i % 20)]});
            end
        end
        tick();
        total++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL rep_max_done: DONE=%b BUSY=%b, want 1/0", DONE, BUSY);
        end
    endtask

    task automatic test_abort();
        logic [19:0] p;
        p = 20'hA5F0C;
        push(M_PAT, p, 8'd0, 4'hF);
        push(M_ONE, 20'd4, 8'd0, 4'hF);
        push(M_ZERO, 20'd4, 8'd0, 4'hF);
        push(M_END, 20'd0, 8'd0, 4'h0);
        pulse_start();
        total++;
        if (fifo_count !== 4'd3) begin
            bad++;
            $display("FAIL abort_queued: cnt=%0d, want 3", fifo_count);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (OUT !== {4{p[19 - i]}}) begin
                bad++;
                $display("FAIL abort_pat cyc %0d: OUT=%h, want %h", i, OUT, {4{p[19 - i]}});
            end
        end
        ABORT = 1'b1;
        wr_en = 1'b1; wr_mode = M_ONE; wr_data = 20'd9; wr_rep = 8'd0; wr_chmask = 4'hF;
        tick();
        ABORT = 1'b0;
        wr_en = 1'b0;
        total++;
        if (OUT !== 4'h0 || fifo_count !== 4'd0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL abort_now: OUT=%h cnt=%0d BUSY=%b DONE=%b, want 0/0/0/0",
                     OUT, fifo_count, BUSY, DONE);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle cyc %0d: OUT=%h DONE=%b BUSY=%b, want 0/0/0",
                         i, OUT, DONE, BUSY);
            end
        end
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (BUSY !== 1'b0 || OUT !== 4'h0 || fifo_count !== 4'd0 || DONE !== 1'b0) begin
                bad++;
                $display("FAIL abort_empty_start cyc %0d: BUSY=%b OUT=%h cnt=%0d DONE=%b, want 0/0/0/0",
                         i, BUSY, OUT, fifo_count, DONE);
            end
        end
    endtask

    task automatic test_async_reset();
        push(M_ONE, 20'd20, 8'd0, 4'hF);
        push(M_ONE, 20'd1, 8'd0, 4'hF);
        push(M_END, 20'd0, 8'd0, 4'h0);
        push(M_ONE, 20'd1, 8'd0, 4'hF);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'hF || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL rst_pre cyc %0d: OUT=%h BUSY=%b, want F/1", i, OUT, BUSY);
            end
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (OUT !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || underrun !== 1'b0 ||
            overflow !== 1'b0 || fifo_count !== 4'd0 || full !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: OUT=%h BUSY=%b DONE=%b und=%b ovf=%b cnt=%0d full=%b, want all 0",
                     OUT, BUSY, DONE, underrun, overflow, fifo_count, full);
        end
        tick();
        RST = 1'b0;
        tick();
        push(M_ONE, 20'd3, 8'd0, 4'h4);
        push(M_END, 20'd0, 8'd0, 4'h0);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (OUT !== 4'h4 || BUSY !== 1'b1) begin
                bad++;
                $display("FAIL rst_fresh cyc %0d: OUT=%h BUSY=%b, want 4/1", i, OUT, BUSY);
            end
        end
        tick();
        total++;
        if (DONE !== 1'b1 || OUT !== 4'h0 || BUSY !== 1'b0 || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL rst_fresh_done: DONE=%b OUT=%h BUSY=%b cnt=%0d, want 1/0/0/0",
                     DONE, OUT, BUSY, fifo_count);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b1;
        START     = 1'b0;
        ABORT     = 1'b0;
        wr_en     = 1'b0;
        wr_mode   = 2'b00;
        wr_data   = 20'd0;
        wr_rep    = 8'd0;
        wr_chmask = 4'h0;
        test_reset();
        test_back_to_back();
        test_const_runs();
        test_underrun();
        test_overflow();
        test_rep_max();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nmr_bstrm_multi_dpath.md
# nmr_bstrm_multi_dpath

Multi-channel, FIFO-fed successor to the NMR bitstream datapath. Per instruction it drives an NCH-wide bitstream: pattern words shifted MSB-first with a repeat count, or constant-high / constant-low runs of programmable length, gated per channel by a mask. An instruction FIFO decouples the sequencer from the output timing, so consecutive instructions play back-to-back with no gap cycles. It sits between the pulse-sequence controller and the TX gate/phase drivers.

## Interface
- DATA_WIDTH, 20, pattern width and constant-run length width
- NCH, 4, number of output channels
- REP_WIDTH, 8, pattern repeat-count width
- FIFO_DEPTH, 8, instruction FIFO depth; power of two, at least 2
- CLK  in  1  clock; all logic is rising-edge
- RST  in  1  asynchronous active-high reset
- START  in  1  begins playback from the FIFO head; sampled in IDLE only
- ABORT  in  1  synchronous abort; returns to IDLE and flushes the FIFO
- wr_en  in  1  instruction write strobe
- wr_mode  in  2  instruction mode: 00 pattern, 01 all-0, 10 all-1, 11 end-of-sequence
- wr_data  in  DATA_WIDTH  pattern bits (pattern mode) or run length (constant modes)
- wr_rep  in  REP_WIDTH  pattern repeats minus 1
- wr_chmask  in  NCH  channel enable mask
- full  out  1  FIFO full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words in the FIFO
- OUT  out  NCH  bitstream outputs, registered
- BUSY  out  1  high in RUN or STALL
- DONE  out  1  one-cycle pulse at end of sequence
- underrun  out  1  sticky flag: FIFO ran empty mid-sequence
- overflow  out  1  sticky flag: write attempted while full

## Operation
- The FIFO is first-word-fall-through. A write is accepted only when full is low at that edge; a pop in the same cycle does not free a slot for it. A dropped write sets overflow.
- A write and a pop in the same cycle on an empty FIFO: the head becomes visible on the next cycle.
- States:
  - IDLE: OUT=0. On START with FIFO non-empty, pop the head and go to RUN. START with FIFO empty is ignored.
  - RUN: play the current instruction.
  - STALL: OUT=0, waiting for an instruction.
- Pattern mode: bits data[DATA_WIDTH-1] down to data[0] play one per cycle. The whole word repeats rep+1 times, for a total of DATA_WIDTH*(rep+1) cycles. Channels with a mask bit of 1 carry the bit; masked-off channels are 0.
- All-1 mode: masked-on channels are 1 for data cycles. All-0 mode: all channels are 0 for data cycles. In both, data=0 is treated as 1 cycle, and wr_rep is ignored.
- End-of-sequence: on pop, OUT=0, DONE pulses, state goes to IDLE.
- On the last cycle of an instruction:
  - FIFO non-empty: pop the next instruction so that its first bit appears on the following cycle (gapless).
  - FIFO empty: go to STALL and set underrun.
- In STALL, pop the head as soon as the FIFO is non-empty. Its first bit appears on the cycle after that pop.
- START received while BUSY is ignored. START accepted in IDLE clears underrun and overflow.
- ABORT has priority over START and over all state transitions:
  - empties the FIFO and sets OUT=0
  - goes to IDLE
  - no DONE pulse
  - a wr_en in the same cycle is dropped

## Timing
- Reset values: OUT=0, DONE=0, BUSY=0, underrun=0, overflow=0, fifo_count=0, full=0; state is IDLE.
- RST asserted mid-sequence forces all reset values immediately, asynchronously, and empties the FIFO.
- START sampled at edge t (IDLE, FIFO non-empty): OUT carries the first bit from edge t+1, and BUSY is high from edge t+1.
- Instruction of length L loaded at edge k: OUT is valid for edges k+1 .. k+L. The next instruction's first bit is at edge k+L+1 when gapless.
- End instruction popped at edge e: DONE is high for edges e+1..e+2 (one cycle), and BUSY goes low at e+1.
- Repeat counter arithmetic: width REP_WIDTH. rep = 2^REP_WIDTH-1 gives 2^REP_WIDTH repeats with no wrap.
- Length counter arithmetic: width DATA_WIDTH. Max run is 2^DATA_WIDTH-1 cycles.

## Test plan
- Load {all-1, data=10, mask=4'b0001}, {pattern 20'b10100011100011101110, rep=1, mask=4'b0011}, {end}; pulse START -> OUT[0] is high for 10 cycles, then the pattern plays twice (40 cycles) on OUT[1:0] with OUT[3:2]=0, then DONE pulses once. OUT has no gap cycles.
- Load {all-0, data=7}, {all-1, data=0, mask=4'hF}, {end} -> 7 cycles of 0, then exactly 1 cycle of 4'hF, then DONE.
- Load {all-1, data=5} only; START; write {end} 3 cycles after the run ends -> STALL with OUT=0, underrun=1, resume, DONE. underrun stays 1 until the next START.
- Write FIFO_DEPTH+1 words in IDLE -> full=1, fifo_count=8, overflow=1, and the last word is absent from playback.
- ABORT mid-pattern with 3 words queued -> OUT=0 next cycle, fifo_count=0, state IDLE, no DONE. A subsequent START with an empty FIFO is ignored.
- Assert RST mid-RUN -> all outputs reach their reset values without waiting for a clock edge. After release, a fresh sequence plays correctly.
